mskaes_round_ctrl: RTL and testbench

Parametrised round controller for the masked AES core. It supports run-time selection of AES-128/192/256 (10/12/14 rounds) and a configurable S-box pipeline latency. It adds a valid/ready input handshake and an output valid/ready handshake with backpressure. It drives the enables, mux selects and valid strobes of the state register, key register, S-box layer and key-schedule datapath. It is purely control; no share data passes through it.

---
 rtl/mskaes_pkg.sv | 27 ++
 rtl/mskaes_cnt.sv | 22 ++
 rtl/mskaes_round_ctrl.sv | 142 ++++++++++++++
 tb/tb_mskaes_round_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mskaes_pkg.sv
// Shared encodings for the masked AES round controller: key sizes, round counts, FSM states.
package mskaes_pkg;

  localparam logic [1:0] KS_128 = 2'd0;
  localparam logic [1:0] KS_192 = 2'd1;
  localparam logic [1:0] KS_256 = 2'd2;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int nr_of(logic [1:0] ks);
    case (ks)
      KS_192:  return NR_192;
      KS_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/mskaes_cnt.sv
// Up-counter with synchronous clear (priority over increment) and async active-high reset.
module mskaes_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mskaes_round_ctrl.sv
// Round sequencer for the masked AES core: Nr rounds of SBOX_LAT+1 cycles, out_valid at accept+Nr*(SBOX_LAT+1)+1.
// Result is held in DONE until out_ready; no block is accepted in DONE, so back-to-back blocks see one bubble.
module mskaes_round_ctrl
  import mskaes_pkg::*;
#(
  parameter int SBOX_LAT = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       key_size,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             feed_in,
  output logic             state_reg_en,
  output logic             key_reg_en,
  output logic             state_mux_last,
  output logic             sb_valid_in,
  output logic             ks_in_valid,
  output logic             ks_rcon_update,
  output logic             ks_rcon_rst,
  output logic [CNT_W-1:0] round_idx,
  output logic [1:0]       key_size_q
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(SBOX_LAT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] round_q;
  logic [CNT_W-1:0] pen_idx;
  logic [1:0]       ks_q;
  logic             accept, busy, rnd_end;

  assign accept  = (state_q == IDLE) && in_valid;
  assign busy    = (state_q == ROUND) || (state_q == LAST);
  assign rnd_end = busy && (cnt == LAT_C);
  assign pen_idx = CNT_W'(nr_of(ks_q) - 2);

  mskaes_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept || rnd_end),
    .inc (busy),
    .q   (cnt)
  );

  mskaes_cnt #(.W(CNT_W)) u_round_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .inc (rnd_end),
    .q   (round_q)
  );

  // Reserved encoding 3 is folded onto AES-128 at capture time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_q <= KS_128;
    end else if (accept) begin
      ks_q <= (key_size == 2'd3) ? KS_128 : key_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    feed_in        = 1'b0;
    state_reg_en   = 1'b0;
    key_reg_en     = 1'b0;
    state_mux_last = 1'b0;
    sb_valid_in    = 1'b0;
    ks_in_valid    = 1'b0;
    ks_rcon_update = 1'b0;
    ks_rcon_rst    = 1'b0;
    round_idx      = round_q;
    key_size_q     = ks_q;

    case (state_q)
      IDLE: begin
        in_ready     = 1'b1;
        feed_in      = 1'b1;
        state_reg_en = 1'b1;
        key_reg_en   = 1'b1;
        if (in_valid) begin
          ks_rcon_rst = 1'b1;
          state_d     = ROUND;
        end
      end
      ROUND, LAST: begin
        sb_valid_in = (cnt == '0);
        ks_in_valid = (cnt == '0);
        if (rnd_end) begin
          state_reg_en   = 1'b1;
          key_reg_en     = 1'b1;
          ks_rcon_update = 1'b1;
          if (state_q == LAST) begin
            state_mux_last = 1'b1;
            state_d        = DONE;
          end else if (round_q == pen_idx) begin
            state_d = LAST;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced low for the whole time reset is asserted.
    if (rst) begin
      in_ready       = 1'b0;
      out_valid      = 1'b0;
      feed_in        = 1'b0;
      state_reg_en   = 1'b0;
      key_reg_en     = 1'b0;
      state_mux_last = 1'b0;
      sb_valid_in    = 1'b0;
      ks_in_valid    = 1'b0;
      ks_rcon_update = 1'b0;
      ks_rcon_rst    = 1'b0;
      round_idx      = '0;
      key_size_q     = 2'd0;
    end
  end

endmodule

// File: tb/tb_mskaes_round_ctrl.sv
// Directed bench for mskaes_round_ctrl: SBOX_LAT=4 instance for all key sizes, SBOX_LAT=1 instance for short rounds.
module tb_mskaes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // SBOX_LAT=4 instance
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] key_size = 2'd0;
  logic       in_ready, out_valid, feed_in, state_reg_en, key_reg_en, state_mux_last;
  logic       sb_valid_in, ks_in_valid, ks_rcon_update, ks_rcon_rst;
  logic [3:0] round_idx;
  logic [1:0] key_size_q;

  // SBOX_LAT=1 instance
  logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [1:0] key_size1 = 2'd0;
  logic       in_ready1, out_valid1, feed_in1, state_reg_en1, key_reg_en1, state_mux_last1;
  logic       sb_valid_in1, ks_in_valid1, ks_rcon_update1, ks_rcon_rst1;
  logic [3:0] round_idx1;
  logic [1:0] key_size_q1;

  int errors = 0;
  int checks = 0;

  localparam logic [9:0] F_IDLE = 10'b0011000110;
  localparam logic [9:0] F_DONE = 10'b0000001000;

  mskaes_round_ctrl #(.SBOX_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key_size(key_size),
    .out_valid(out_valid), .out_ready(out_ready), .feed_in(feed_in),
    .state_reg_en(state_reg_en), .key_reg_en(key_reg_en), .state_mux_last(state_mux_last),
    .sb_valid_in(sb_valid_in), .ks_in_valid(ks_in_valid), .ks_rcon_update(ks_rcon_update),
    .ks_rcon_rst(ks_rcon_rst), .round_idx(round_idx), .key_size_q(key_size_q)
  );

  mskaes_round_ctrl #(.SBOX_LAT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .key_size(key_size1),
    .out_valid(out_valid1), .out_ready(out_ready1), .feed_in(feed_in1),
    .state_reg_en(state_reg_en1), .key_reg_en(key_reg_en1), .state_mux_last(state_mux_last1),
    .sb_valid_in(sb_valid_in1), .ks_in_valid(ks_in_valid1), .ks_rcon_update(ks_rcon_update1),
    .ks_rcon_rst(ks_rcon_rst1), .round_idx(round_idx1), .key_size_q(key_size_q1)
  );

  // Bit order: sb, ks_in, state_en, key_en, rcon_upd, mux_last, out_valid, in_ready, feed_in, rcon_rst
  function automatic logic [9:0] flags0();
    return {sb_valid_in, ks_in_valid, state_reg_en, key_reg_en, ks_rcon_update,
            state_mux_last, out_valid, in_ready, feed_in, ks_rcon_rst};
  endfunction

  function automatic logic [9:0] flags1();
    return {sb_valid_in1, ks_in_valid1, state_reg_en1, key_reg_en1, ks_rcon_update1,
            state_mux_last1, out_valid1, in_ready1, feed_in1, ks_rcon_rst1};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic start_block(input string tag, input logic [1:0] ks);
    @(posedge clk); #1;
    in_valid = 1'b1;
    key_size = ks;
    #1;
    checks++;
    if ({in_ready, ks_rcon_rst} !== 2'b11) begin
      errors++;
      $display("FAIL %s accept: in_ready,ks_rcon_rst=%b expected 11", tag, {in_ready, ks_rcon_rst});
    end
  endtask

  // Walks cycles t0+1 .. t0+Nr*5+1 and compares every strobe against the round schedule.
  task automatic run_trace(input string tag, input int nr, input bit hold_valid,
                           input bit toggle_ks, input logic [1:0] exp_ksq, output int upd);
    logic [9:0] exp_f;
    int         exp_idx;
    bit         inround, sb, edg;
    upd = 0;
    for (int k = 1; k <= nr * 5 + 1; k++) begin
      @(posedge clk); #1;
      if (!hold_valid) in_valid = 1'b0;
      if (toggle_ks) key_size = key_size + 2'd1;
      #1;
      inround = (k <= nr * 5);
      sb      = inround && ((k - 1) % 5 == 0);
      edg     = inround && (k % 5 == 0);
      exp_f   = {sb, sb, edg, edg, edg, edg && (k == nr * 5), (k == nr * 5 + 1), 1'b0, 1'b0, 1'b0};
      exp_idx = inround ? (k - 1) / 5 : nr;
      checks++;
      if (flags0() !== exp_f || round_idx !== 4'(exp_idx) || key_size_q !== exp_ksq) begin
        errors++;
        $display("FAIL %s t0+%0d: flags=%b idx=%0d ksq=%0d, expected flags=%b idx=%0d ksq=%0d",
                 tag, k, flags0(), round_idx, key_size_q, exp_f, exp_idx, exp_ksq);
      end
      if (ks_rcon_update === 1'b1) upd++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (flags0() !== 10'b0 || round_idx !== 4'd0 || key_size_q !== 2'd0) begin
      errors++;
      $display("FAIL reset_held: flags=%b idx=%0d ksq=%0d expected all 0", flags0(), round_idx, key_size_q);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (flags0() !== F_IDLE || round_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_release: flags=%b idx=%0d expected %b idx=0", flags0(), round_idx, F_IDLE);
    end
    // Reset in round 3, cnt 2 (cycle t0+18) of an AES-256 block
    start_block("mid_reset", 2'd2);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    #1;
    checks++;
    if (round_idx !== 4'd3 || sb_valid_in !== 1'b0 || key_size_q !== 2'd2) begin
      errors++;
      $display("FAIL mid_reset_pre: idx=%0d sb=%b ksq=%0d expected idx=3 sb=0 ksq=2", round_idx, sb_valid_in, key_size_q);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (flags0() !== 10'b0 || flags1() !== 10'b0 || round_idx !== 4'd0 || key_size_q !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_assert: flags=%b flags1=%b idx=%0d ksq=%0d expected all 0",
               flags0(), flags1(), round_idx, key_size_q);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (flags0() !== F_IDLE || round_idx !== 4'd0 || key_size_q !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_release: flags=%b idx=%0d ksq=%0d expected %b idx=0 ksq=0",
               flags0(), round_idx, key_size_q, F_IDLE);
    end
    @(posedge clk); #2;
    checks++;
    if (flags0() !== F_IDLE) begin
      errors++;
      $display("FAIL mid_reset_idle: flags=%b expected %b", flags0(), F_IDLE);
    end
  endtask

  task automatic test_aes128();
    int upd;
    do_reset();
    start_block("aes128", 2'd0);
    run_trace("aes128", 10, 1'b0, 1'b0, 2'd0, upd);
    checks++;
    if (upd != 10) begin
      errors++;
      $display("FAIL aes128_rcon_updates: got %0d expected 10", upd);
    end
  endtask

  task automatic test_backpressure();
    int upd;
    do_reset();
    start_block("aes256", 2'd2);
    run_trace("aes256", 14, 1'b0, 1'b0, 2'd2, upd);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      checks++;
      if (flags0() !== F_DONE || key_size_q !== 2'd2 || round_idx !== 4'd14) begin
        errors++;
        $display("FAIL aes256_hold %0d: flags=%b ksq=%0d idx=%0d expected %b ksq=2 idx=14",
                 i, flags0(), key_size_q, round_idx, F_DONE);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (flags0() !== F_DONE) begin
      errors++;
      $display("FAIL aes256_release: flags=%b expected %b", flags0(), F_DONE);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    checks++;
    if (flags0() !== F_IDLE) begin
      errors++;
      $display("FAIL aes256_idle: flags=%b expected %b", flags0(), F_IDLE);
    end
  endtask

  task automatic test_ks_reserved();
    int upd;
    do_reset();
    start_block("ks3", 2'd3);
    run_trace("ks3", 10, 1'b0, 1'b0, 2'd0, upd);
    checks++;
    if (upd != 10) begin
      errors++;
      $display("FAIL ks3_rcon_updates: got %0d expected 10", upd);
    end
  endtask

  task automatic test_back_to_back();
    int upd;
    do_reset();
    start_block("aes192", 2'd1);
    run_trace("aes192", 12, 1'b1, 1'b1, 2'd1, upd);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      checks++;
      if (flags0() !== F_DONE) begin
        errors++;
        $display("FAIL b2b_done_no_accept %0d: flags=%b expected %b", i, flags0(), F_DONE);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    key_size  = 2'd2;
    #1;
    checks++;
    if (flags0() !== (F_IDLE | 10'b1)) begin
      errors++;
      $display("FAIL b2b_idle_accept: flags=%b expected %b", flags0(), F_IDLE | 10'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (flags0() !== 10'b1100000000 || round_idx !== 4'd0 || key_size_q !== 2'd2) begin
      errors++;
      $display("FAIL b2b_second_start: flags=%b idx=%0d ksq=%0d expected 1100000000 idx=0 ksq=2",
               flags0(), round_idx, key_size_q);
    end
  endtask

  task automatic test_sbox_lat1();
    logic [9:0] exp_f;
    int         upd;
    bit         inround, sb, edg;
    do_reset();
    @(posedge clk); #1;
    in_valid1 = 1'b1;
    key_size1 = 2'd0;
    #1;
    checks++;
    if ({in_ready1, ks_rcon_rst1} !== 2'b11) begin
      errors++;
      $display("FAIL lat1 accept: in_ready,ks_rcon_rst=%b expected 11", {in_ready1, ks_rcon_rst1});
    end
    upd = 0;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      #1;
      inround = (k <= 20);
      sb      = inround && ((k - 1) % 2 == 0);
      edg     = inround && (k % 2 == 0);
      exp_f   = {sb, sb, edg, edg, edg, (k == 20), (k == 21), 1'b0, 1'b0, 1'b0};
      checks++;
      if (flags1() !== exp_f) begin
        errors++;
        $display("FAIL lat1 t0+%0d: flags=%b expected %b", k, flags1(), exp_f);
      end
      if (ks_rcon_update1 === 1'b1) upd++;
    end
    checks++;
    if (upd != 10 || round_idx1 !== 4'd10) begin
      errors++;
      $display("FAIL lat1_totals: updates=%0d idx=%0d expected 10 and 10", upd, round_idx1);
    end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_backpressure();
    test_ks_reserved();
    test_back_to_back();
    test_sbox_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
